// File: rtl/riscv_pkg.sv
// RV32I shared definitions: opcodes, instruction formats, decoded-field bundle.
// Imported by the decoder and the instruction encoder.
package riscv_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD    = 7'b0000011,
        OPC_MISCMEM = 7'b0001111,
        OPC_OPIMM   = 7'b0010011,
        OPC_AUIPC   = 7'b0010111,
        OPC_STORE   = 7'b0100011,
        OPC_OP      = 7'b0110011,
        OPC_LUI     = 7'b0110111,
        OPC_BRANCH  = 7'b1100011,
        OPC_JALR    = 7'b1100111,
        OPC_JAL     = 7'b1101111,
        OPC_SYSTEM  = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    localparam int INSTR_W = 32;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OPC_LUI, OPC_AUIPC: f = FMT_U;
            OPC_JAL:            f = FMT_J;
            OPC_JALR,
            OPC_LOAD,
            OPC_OPIMM,
            OPC_MISCMEM,
            OPC_SYSTEM:         f = FMT_I;
            OPC_STORE:          f = FMT_S;
            OPC_BRANCH:         f = FMT_B;
            OPC_OP:             f = FMT_R;
            default:            f = FMT_X;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Output buffer of the instruction encoder: DEPTH-entry FIFO.
// Read data reads as zero whenever the buffer is empty.
module instr_enc_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = INSTR_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = empty ? '0 : mem[rp];

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: decoded fields in, 32-bit words out via a FIFO.
// Define INSTR_ENC_ILLEGAL_CHECK_EN to flag (and zero) unencodable words.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] enc_count
);

    dec_t        d;
    fmt_e        fmt;
    logic        shamt;
    logic [31:0] raw;
    logic [31:0] word;
    logic        illegal;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [32:0] dout;

    assign d = '{
        opcode: in_opcode,
        funct3: in_funct3,
        funct7: in_funct7,
        rd:     in_rd,
        rs1:    in_rs1,
        rs2:    in_rs2,
        imm:    in_imm
    };

    assign fmt   = fmt_of(d.opcode);
    assign shamt = (d.opcode == OPC_OPIMM) && (d.funct3[1:0] == 2'b01);

    always_comb begin
        raw = '0;
        unique case (1'b1)
            fmt == FMT_U:
                raw = {d.imm[31:12], d.rd, d.opcode};
            fmt == FMT_J:
                raw = {d.imm[20], d.imm[10:1], d.imm[11],
                       d.imm[19:12], d.rd, d.opcode};
            fmt == FMT_I && shamt:
                raw = {d.funct7, d.imm[4:0], d.rs1,
                       d.funct3, d.rd, d.opcode};
            fmt == FMT_I && !shamt:
                raw = {d.imm[11:0], d.rs1, d.funct3,
                       d.rd, d.opcode};
            fmt == FMT_S:
                raw = {d.imm[11:5], d.rs2, d.rs1,
                       d.funct3, d.imm[4:0], d.opcode};
            fmt == FMT_B:
                raw = {d.imm[12], d.imm[10:5], d.rs2, d.rs1,
                       d.funct3, d.imm[4:1], d.imm[11], d.opcode};
            default:
                raw = {d.funct7, d.rs2, d.rs1,
                       d.funct3, d.rd, d.opcode};
        endcase
    end

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    logic imm12_ok;

    assign imm12_ok = (&d.imm[31:11]) | ~(|d.imm[31:11]);

    always_comb begin
        illegal = 1'b0;
        case (fmt)
            FMT_X:        illegal = 1'b1;
            FMT_B, FMT_J: illegal = d.imm[0];
            FMT_I, FMT_S: illegal = !imm12_ok;
            FMT_U:        illegal = |d.imm[11:0];
            default:      illegal = 1'b0;
        endcase
        case (d.opcode)
            OPC_OP:
                if (d.funct7 != 7'h00 && d.funct7 != 7'h20)
                    illegal = 1'b1;
            OPC_LOAD:
                if (d.funct3 == 3'b011 || d.funct3[2:1] == 2'b11)
                    illegal = 1'b1;
            OPC_STORE:
                if (d.funct3 > 3'b010)
                    illegal = 1'b1;
            OPC_BRANCH:
                if (d.funct3[2:1] == 2'b01)
                    illegal = 1'b1;
            OPC_JALR:
                if (d.funct3 != 3'b000)
                    illegal = 1'b1;
            default: ;
        endcase
    end

    assign word = illegal ? '0 : raw;
`else
    assign illegal = 1'b0;
    assign word    = raw;
`endif

    // no pass-through: a full buffer refuses even if the consumer pops
    assign in_ready  = rst_n & ~full;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({illegal, word}),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign out_instr   = dout[31:0];
    assign out_illegal = dout[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (push) begin
            enc_count <= enc_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against an arithmetic reference model.
// Directed words pin the model to hand-encoded RV32I values.
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] MISC   = 7'h0F;
    localparam logic [6:0] OPIMM  = 7'h13;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] SYS    = 7'h73;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             out_illegal;
    logic [CNT_W-1:0] enc_count;

    int checks = 0;
    int errors = 0;

    logic [32:0]      mq[$];
    logic [CNT_W-1:0] mcount = '0;

    always #5 clk = ~clk;

    instr_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .enc_count   (enc_count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit in12(input logic [31:0] imm);
        int s;
        s = $signed(imm);
        return s >= -2048 && s <= 2047;
    endfunction

    function automatic logic [32:0] model(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [31:0] imm);
        logic [31:0] w, o, d, s1, s2, t, f7w;
        bit ill;
        o   = 32'(op);
        d   = 32'(rd) << 7;
        s1  = 32'(rs1) << 15;
        s2  = 32'(rs2) << 20;
        t   = 32'(f3) << 12;
        f7w = 32'(f7) << 25;
        ill = 1'b0;
        case (op)
            LUI, AUIPC: begin
                w   = (imm & 32'hFFFFF000) | d | o;
                ill = (imm & 32'hFFF) != 0;
            end
            JAL: begin
                w = (((imm >> 20) & 1) << 31)
                  | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12) | d | o;
                ill = imm[0];
            end
            JALR, LOAD, MISC, SYS, OPIMM: begin
                if (op == OPIMM && (f3 == 1 || f3 == 5))
                    w = f7w | ((imm & 31) << 20) | s1 | t | d | o;
                else
                    w = ((imm & 32'hFFF) << 20) | s1 | t | d | o;
                ill = !in12(imm)
                    || (op == LOAD && (f3 == 3 || f3 >= 6))
                    || (op == JALR && f3 != 0);
            end
            STORE: begin
                w = (((imm >> 5) & 127) << 25) | s2 | s1 | t
                  | ((imm & 31) << 7) | o;
                ill = !in12(imm) || f3 > 2;
            end
            BRANCH: begin
                w = (((imm >> 12) & 1) << 31)
                  | (((imm >> 5) & 63) << 25) | s2 | s1 | t
                  | (((imm >> 1) & 15) << 8)
                  | (((imm >> 11) & 1) << 7) | o;
                ill = imm[0] || f3 == 2 || f3 == 3;
            end
            OP: begin
                w   = f7w | s2 | s1 | t | d | o;
                ill = f7 != 0 && f7 != 7'h20;
            end
            default: begin
                w   = f7w | s2 | s1 | t | d | o;
                ill = 1'b1;
            end
        endcase
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
        if (ill) w = '0;
        return {ill, w};
`else
        return {1'b0, w};
`endif
    endfunction

    initial begin : mdl
        bit acc;
        bit pp;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mcount = '0;
            end else begin
                acc = in_valid && mq.size() < DEPTH;
                pp  = mq.size() != 0 && out_ready;
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(model(in_opcode, in_funct3, in_funct7,
                                       in_rd, in_rs1, in_rs2, in_imm));
                    mcount = mcount + 1;
                end
            end
        end
    end

    initial begin : cmp
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", out_valid, 0);
                chk("rst_ready", in_ready, 0);
                chk("rst_count", enc_count, 0);
                chk("rst_instr", out_instr, 0);
                chk("rst_illegal", out_illegal, 0);
            end else begin
                chk("valid", out_valid, mq.size() != 0);
                chk("ready", in_ready, mq.size() < DEPTH);
                chk("count", enc_count, mcount);
                if (mq.size() != 0) begin
                    chk("instr", out_instr, mq[0][31:0]);
                    chk("illegal", out_illegal, mq[0][32]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        chk("reset_async_count", enc_count, 0);
        tick;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready_after", in_ready, 1);
        tick;
    endtask

    task automatic send_dir(input string name, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] exp_w, input logic exp_i);
        set_in(op, f3, f7, rd, rs1, rs2, imm);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_instr"}, out_instr, exp_w);
        chk({name, "_illegal"}, out_illegal, exp_i);
        tick;
    endtask

    logic [6:0] ops [11] = '{LOAD, MISC, OPIMM, AUIPC, STORE, OP,
                             LUI, BRANCH, JALR, JAL, SYS};

    initial begin
        logic [31:0] br_w;
        logic        br_i;
        logic [31:0] rimm;
        logic [6:0]  rf7;
        logic [6:0]  rop;

        #3;
        do_reset;

        send_dir("addi", OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                 32'd5, 32'h00500093, 1'b0);
        send_dir("sub", OP, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2,
                 32'd0, 32'h402081B3, 1'b0);
        send_dir("lui", LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
                 32'h12345000, 32'h123452B7, 1'b0);
        send_dir("beq", BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2,
                 32'd8, 32'h00208463, 1'b0);
        send_dir("jal", JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                 32'd2048, 32'h001000EF, 1'b0);
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
        br_w = 32'h0;
        br_i = 1'b1;
`else
        br_w = 32'h00208163;
        br_i = 1'b0;
`endif
        send_dir("beq_odd", BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2,
                 32'd3, br_w, br_i);

        do_reset;
        out_ready = 1'b0;
        set_in(OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        tick;
        set_in(OP, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        tick;
        set_in(LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        @(negedge clk);
        chk("full_ready_a", in_ready, 0);
        tick;
        @(negedge clk);
        chk("full_ready_b", in_ready, 0);
        chk("full_head", out_instr, 32'h00500093);
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_w1", out_instr, 32'h00500093);
        tick;
        @(negedge clk);
        chk("drain_w2", out_instr, 32'h402081B3);
        chk("drain_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_w3", out_instr, 32'h123452B7);
        tick;
        @(negedge clk);
        chk("drain_empty", out_valid, 0);
        chk("drain_count", enc_count, 3);
        tick;

        out_ready = 1'b0;
        set_in(OP, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b1;
        tick;
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", enc_count, 0);
        #1;
        rst_n = 1'b1;
        tick;
        set_in(OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("alone_instr", out_instr, 32'h00500093);
        chk("alone_count", enc_count, 1);
        tick;
        out_ready = 1'b1;
        tick;
        @(negedge clk);
        chk("alone_gone", out_valid, 0);
        tick;

        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 4)
                0: rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: rimm = $urandom;
                2: rimm = $urandom & 32'hFFFFF000;
                default: rimm = (32'($urandom_range(0, 2047))
                                 - 32'd1024) << 1;
            endcase
            case ($urandom % 3)
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                default: rf7 = 7'($urandom);
            endcase
            rop = ops[$urandom % 11];
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
            if ($urandom % 16 == 0) rop = 7'($urandom);
`endif
            set_in(rop, 3'($urandom), rf7, 5'($urandom),
                   5'($urandom), 5'($urandom), rimm);
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 6;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick;
        @(negedge clk);
        chk("final_drain", out_valid, 0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
